// File: rtl/load_store_unit.sv
// Data-memory access stage: runs one request/ready bus transaction per load/store,
// stalls the datapath while it is in flight and returns lane-aligned load data.
//
// state   | meaning
// IDLE    | waiting for a load/store; misaligned word accesses fault here
// REQUEST | bus_request high, latched fields on the bus, waiting for bus_ready
// DONE    | load data valid, stall released so the datapath commits
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic        byte_access,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        fault,
    output logic        bus_request,
    output logic        bus_write,
    output logic [31:0] bus_address,
    output logic [3:0]  bus_byte_enable,
    output logic [31:0] bus_write_data,
    input  logic        bus_ready,
    input  logic [31:0] bus_read_data
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_W = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQUEST,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          bus_write_q, bus_write_d;
    logic [31:0]   bus_address_q, bus_address_d;
    logic [3:0]    byte_enable_q, byte_enable_d;
    logic [31:0]   write_data_q, write_data_d;
    logic          byte_q, byte_d;
    logic [1:0]    lane_q, lane_d;
    logic [31:0]   read_data_q, read_data_d;

    logic access;
    logic misaligned;
    logic stall_c;
    logic fault_c;
    logic zero_read_c;

    assign access     = memory_read | memory_write;
    assign misaligned = !byte_access && (address[1:0] != 2'b00);

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        bus_write_d   = bus_write_q;
        bus_address_d = bus_address_q;
        byte_enable_d = byte_enable_q;
        write_data_d  = write_data_q;
        byte_d        = byte_q;
        lane_d        = lane_q;
        read_data_d   = read_data_q;
        stall_c       = 1'b0;
        fault_c       = 1'b0;
        zero_read_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        fault_c     = 1'b1;
                        zero_read_c = 1'b1;
                        read_data_d = '0;
                    end else begin
                        stall_c       = 1'b1;
                        state_d       = S_REQUEST;
                        wait_d        = '0;
                        bus_write_d   = memory_write;
                        bus_address_d = {address[31:2], 2'b00};
                        byte_enable_d = byte_access ? (4'b0001 << address[1:0]) : 4'b1111;
                        write_data_d  = byte_access ? {4{write_data[7:0]}} : write_data;
                        byte_d        = byte_access;
                        lane_d        = address[1:0];
                    end
                end
            end

            S_REQUEST: begin
                stall_c = 1'b1;
                // A ready arriving in the timeout cycle still completes the access.
                if (bus_ready) begin
                    state_d = S_DONE;
                    if (!bus_write_q) begin
                        read_data_d = byte_q ? {24'b0, bus_read_data[{lane_q, 3'b000} +: 8]}
                                             : bus_read_data;
                    end
                end else if (wait_q == TIMEOUT_W) begin
                    fault_c     = 1'b1;
                    read_data_d = '0;
                    state_d     = S_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wait_q        <= '0;
            bus_write_q   <= 1'b0;
            bus_address_q <= '0;
            byte_enable_q <= '0;
            write_data_q  <= '0;
            byte_q        <= 1'b0;
            lane_q        <= '0;
            read_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            bus_write_q   <= bus_write_d;
            bus_address_q <= bus_address_d;
            byte_enable_q <= byte_enable_d;
            write_data_q  <= write_data_d;
            byte_q        <= byte_d;
            lane_q        <= lane_d;
            read_data_q   <= read_data_d;
        end
    end

    assign stall           = stall_c & ~reset;
    assign fault           = fault_c & ~reset;
    assign read_data       = zero_read_c ? 32'h0 : read_data_q;
    assign bus_request     = (state_q == S_REQUEST);
    assign bus_write       = bus_write_q;
    assign bus_address     = bus_address_q;
    assign bus_byte_enable = byte_enable_q;
    assign bus_write_data  = write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level model of
// stall length, bus fields, fault timing and returned load data.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        memory_read;
    logic        memory_write;
    logic        byte_access;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic        fault;
    logic        bus_request;
    logic        bus_write;
    logic [31:0] bus_address;
    logic [3:0]  bus_byte_enable;
    logic [31:0] bus_write_data;
    logic        bus_ready;
    logic [31:0] bus_read_data;

    int          n_chk = 0;
    int          n_bad = 0;
    logic [31:0] rd_model;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clock          (clock),
        .reset          (reset),
        .memory_read    (memory_read),
        .memory_write   (memory_write),
        .byte_access    (byte_access),
        .address        (address),
        .write_data     (write_data),
        .read_data      (read_data),
        .stall          (stall),
        .fault          (fault),
        .bus_request    (bus_request),
        .bus_write      (bus_write),
        .bus_address    (bus_address),
        .bus_byte_enable(bus_byte_enable),
        .bus_write_data (bus_write_data),
        .bus_ready      (bus_ready),
        .bus_read_data  (bus_read_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        memory_read   = 1'b0;
        memory_write  = 1'b0;
        byte_access   = 1'($urandom);
        address       = $urandom;
        write_data    = $urandom;
        bus_ready     = 1'($urandom);
        bus_read_data = $urandom;
    endtask

    // lat = number of REQUEST cycles without ready; lat > TO means ready never comes
    task automatic do_access(input bit wr, input bit rd_too, input bit bt,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int lat, input logic [31:0] rdat);
        bit          mis;
        bit          to;
        int          last;
        int          n_stall;
        logic [31:0] exp_rd;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [1:0]  lane;

        lane   = addr[1:0];
        mis    = !bt && (lane != 2'b00);
        to     = lat > TO;
        last   = to ? TO : lat;
        exp_be = bt ? 4'(1 << lane) : 4'hF;
        exp_wd = bt ? {wd[7:0], wd[7:0], wd[7:0], wd[7:0]} : wd;

        @(posedge clock); #1;
        memory_write  = wr;
        memory_read   = wr ? rd_too : 1'b1;
        byte_access   = bt;
        address       = addr;
        write_data    = wd;
        bus_ready     = 1'($urandom);
        bus_read_data = $urandom;
        @(negedge clock);

        if (mis) begin
            chk("mis_fault", fault, 1);
            chk("mis_stall", stall, 0);
            chk("mis_req", bus_request, 0);
            chk("mis_rdata", read_data, 0);
            rd_model = 32'h0;
            @(posedge clock); #1;
            idle_inputs();
            @(negedge clock);
            chk("mis_noreq", bus_request, 0);
            chk("mis_nofault", fault, 0);
            chk("mis_after_rdata", read_data, rd_model);
            return;
        end

        chk("idle_stall", stall, 1);
        chk("idle_fault", fault, 0);
        chk("idle_req", bus_request, 0);
        n_stall = int'(stall);

        for (int k = 0; k <= last; k++) begin
            @(posedge clock); #1;
            bus_ready     = (k == lat);
            bus_read_data = (k == lat) ? rdat : $urandom;
            address       = $urandom;
            write_data    = $urandom;
            byte_access   = 1'($urandom);
            @(negedge clock);
            n_stall += int'(stall);
            chk("req_valid", bus_request, 1);
            chk("req_stall", stall, 1);
            chk("req_write", bus_write, wr);
            chk("req_addr", bus_address, addr & 32'hFFFF_FFFC);
            chk("req_be", bus_byte_enable, exp_be);
            if (wr) chk("req_wdata", bus_write_data, exp_wd);
            chk("req_fault", fault, (to && k == TO));
        end

        if (to)
            exp_rd = 32'h0;
        else if (wr)
            exp_rd = rd_model;
        else if (bt)
            exp_rd = (rdat >> (8 * lane)) & 32'hFF;
        else
            exp_rd = rdat;

        @(posedge clock); #1;
        bus_ready     = 1'($urandom);
        bus_read_data = $urandom;
        address       = addr;
        write_data    = wd;
        byte_access   = bt;
        @(negedge clock);
        n_stall += int'(stall);
        chk("done_stall", stall, 0);
        chk("done_fault", fault, 0);
        chk("done_req", bus_request, 0);
        chk("done_rdata", read_data, exp_rd);
        rd_model = exp_rd;
        chk("stall_cycles", n_stall, last + 2);

        @(posedge clock); #1;
        idle_inputs();
        @(negedge clock);
        chk("idle_after_req", bus_request, 0);
        chk("idle_after_stall", stall, 0);
        chk("idle_after_rdata", read_data, rd_model);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        memory_read = 1'b1;
        address     = 32'h0;
        byte_access = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_stall", stall, 0);
        chk("rst_fault", fault, 0);
        chk("rst_req", bus_request, 0);
        chk("rst_write", bus_write, 0);
        chk("rst_addr", bus_address, 0);
        chk("rst_be", bus_byte_enable, 0);
        chk("rst_wdata", bus_write_data, 0);
        chk("rst_rdata", read_data, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        idle_inputs();
        rd_model = 32'h0;

        do_access(1'b0, 1'b0, 1'b0, 32'h0000_0104, 32'h0, 0, 32'hDEAD_BEEF);
        do_access(1'b1, 1'b0, 1'b1, 32'h0000_0203, 32'h1234_56A5, 3, 32'h0);
        do_access(1'b0, 1'b0, 1'b1, 32'h0000_0011, 32'h0, 1, 32'h1122_3344);
        do_access(1'b0, 1'b0, 1'b0, 32'h0000_0002, 32'h0, 0, 32'h0);
        do_access(1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 2, 32'hCAFE_F00D);
        do_access(1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h0, TO + 5, 32'h5555_AAAA);
        do_access(1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'h0, TO, 32'h0BAD_F00D);
        do_access(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h8765_4321, 0, 32'h0);

        // Reset during the second REQUEST cycle abandons the access silently.
        @(posedge clock); #1;
        memory_read  = 1'b1;
        memory_write = 1'b0;
        byte_access  = 1'b0;
        address      = 32'h0000_0040;
        bus_ready    = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_stall", stall, 0);
        chk("midrst_fault", fault, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        idle_inputs();
        @(negedge clock);
        chk("postrst_req", bus_request, 0);
        chk("postrst_stall", stall, 0);
        chk("postrst_fault", fault, 0);
        chk("postrst_rdata", read_data, 0);
        rd_model = 32'h0;

        for (int t = 0; t < 80; t++) begin
            bit          wr;
            bit          bt;
            logic [31:0] addr;
            int          lat;
            int          sel;
            wr   = 1'($urandom);
            bt   = 1'($urandom);
            addr = $urandom;
            if (!bt && ($urandom_range(3) != 0)) addr[1:0] = 2'b00;
            sel = $urandom_range(9);
            if (sel == 0)
                lat = TO;
            else if (sel == 1 && !wr)
                lat = TO + 1 + $urandom_range(2);
            else
                lat = $urandom_range(5);
            do_access(wr, 1'($urandom), bt, addr, $urandom, lat, $urandom);
            if ($urandom_range(1) != 0) begin
                @(posedge clock); #1;
                idle_inputs();
                @(negedge clock);
                chk("gap_stall", stall, 0);
                chk("gap_rdata", read_data, rd_model);
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
